// File: rtl/buffer_ctrl_pkg.sv
// Shared constants and grant encoding for the buffer controller.
// Optional almost_full output is enabled by BUFFER_CTRL_ALMOST_FULL_EN.
package buffer_ctrl_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_W    = 2'd1,
        GRANT_R    = 2'd2
    } grant_e;
endpackage

// File: rtl/buffer_ctrl_arb.sv
// Round-robin arbiter between buffer write and buffer read requests.
// Only contended cycles toggle the fairness flag.
module buffer_ctrl_arb
    import buffer_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   want_w,
    input  logic   want_r,
    output grant_e grant
);
    // Set when the most recent contended grant went to write.
    logic last_w_q, last_w_d;

    always_comb begin
        grant    = GRANT_NONE;
        last_w_d = last_w_q;
        if (want_w && want_r) begin
            grant    = last_w_q ? GRANT_R : GRANT_W;
            last_w_d = !last_w_q;
        end else if (want_w) begin
            grant = GRANT_W;
        end else if (want_r) begin
            grant = GRANT_R;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_w_q <= 1'b0;
        end else begin
            last_w_q <= last_w_d;
        end
    end
endmodule

// File: rtl/buffer_ctrl.sv
// Controller for a single-port-per-cycle 16-bit buffer memory (FIFO order).
// Define BUFFER_CTRL_ALMOST_FULL_EN to add AF_MARGIN and almost_full.
module buffer_ctrl
    import buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W = 4
`ifdef BUFFER_CTRL_ALMOST_FULL_EN
  , parameter int AF_MARGIN = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_w,
    output logic              mem_r,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
`ifdef BUFFER_CTRL_ALMOST_FULL_EN
  , output logic              almost_full
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              out_valid_q, out_valid_d;

    logic   want_w, want_r;
    logic   gnt_w, gnt_r;
    grant_e grant;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // rst gating keeps strobes low while reset is held.
    assign want_w = rst && in_valid && !full;
    assign want_r = rst && !empty && (!out_valid_q || out_ready);

    buffer_ctrl_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .want_w (want_w),
        .want_r (want_r),
        .grant  (grant)
    );

    always_comb begin
        gnt_w       = (grant == GRANT_W);
        gnt_r       = (grant == GRANT_R);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q && !out_ready;
        if (gnt_w) begin
            wptr_d  = wptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W + 1)'(1);
        end
        if (gnt_r) begin
            rptr_d      = rptr_q + ADDR_W'(1);
            count_d     = count_q - (ADDR_W + 1)'(1);
            out_valid_d = 1'b1;
        end
    end

    assign in_ready   = gnt_w;
    assign mem_w      = gnt_w;
    assign mem_r      = gnt_r;
    assign mem_w_addr = wptr_q;
    assign mem_r_addr = rptr_q;
    assign mem_wdata  = in_data;
    assign out_data   = mem_rdata;
    assign out_valid  = out_valid_q;
    assign count      = count_q;

`ifdef BUFFER_CTRL_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(DEPTH - AF_MARGIN);
    assign almost_full = (count_q >= AF_CNT);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl with a registered-read memory model
// and an ordering scoreboard over every accepted/consumed word.
module tb_buffer_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic        mem_w, mem_r;
    logic [3:0]  mem_w_addr, mem_r_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [4:0]  count;
    logic        full, empty;
`ifdef BUFFER_CTRL_ALMOST_FULL_EN
    logic        almost_full;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] mem [16];
    logic [15:0] exp_q [$];
    logic [15:0] nxt;
    logic        acc;
    logic        prev_w;
    int          pushed;

    always #5 clk = ~clk;

    buffer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mem_w      (mem_w),
        .mem_r      (mem_r),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef BUFFER_CTRL_ALMOST_FULL_EN
      , .almost_full(almost_full)
`endif
    );

    always @(posedge clk) begin
        if (mem_w) mem[mem_w_addr] <= mem_wdata;
        if (mem_r) mem_rdata <= mem[mem_r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        #1;
        acc = in_ready;
        if (in_ready) exp_q.push_back(in_data);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("order", out_data, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_until(input int tgt);
        int n = 0;
        in_valid = 1'b1;
        while (int'(count) != tgt && n < 100) begin
            in_data = nxt;
            tick();
            if (acc) nxt++;
            n++;
        end
        in_valid = 1'b0;
        chk("push_bound", 32'(n < 100), 1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!(empty && !out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_bound", 32'(n < 100), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0005;
        out_ready = 1'b0;
        mem_rdata = '0;
        nxt = 16'h0020;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_w", mem_w, 0);
        chk("rst_mem_r", mem_r, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_out_valid", out_valid, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fill: uncontended write, contended write, then contended read.
        in_valid = 1'b1;
        in_data = 16'h0001;
        #1;
        chk("w0_mem_w", mem_w, 1);
        chk("w0_addr", mem_w_addr, 0);
        chk("w0_mem_r", mem_r, 0);
        tick();
        chk("w0_count", count, 1);
        in_data = 16'h0002;
        #1;
        chk("w1_mem_w", mem_w, 1);
        chk("w1_mem_r", mem_r, 0);
        chk("w1_addr", mem_w_addr, 1);
        tick();
        chk("w1_count", count, 2);
        in_data = 16'h0003;
        #1;
        chk("r0_in_ready", in_ready, 0);
        chk("r0_mem_r", mem_r, 1);
        chk("r0_addr", mem_r_addr, 0);
        tick();
        chk("r0_out_valid", out_valid, 1);
        chk("r0_out_data", out_data, 16'h0001);
        chk("r0_count", count, 1);
        for (int d = 3; d <= 16; d++) begin
            in_data = 16'(d);
            tick();
            chk("fill_acc", acc, 1);
        end
        chk("fill_count15", count, 15);
        chk("fill_not_full", full, 0);
        in_data = 16'h0011;
        tick();
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        in_data = 16'h0012;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_mem_w", mem_w, 0);
        in_valid = 1'b0;

        // Drain from full; out_valid must hold through back-to-back reads.
        out_ready = 1'b1;
        #1;
        chk("drain_mem_r", mem_r, 1);
        chk("drain_addr", mem_r_addr, 1);
        drain();
        chk("drain_empty", empty, 1);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_count", count, 0);
        chk("drain_sb", 32'(exp_q.size()), 0);

        // Contended steady state at count 4/5.
        out_ready = 1'b0;
        push_until(4);
        chk("ctn_out_valid", out_valid, 1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = nxt;
            #1;
            chk("ctn_excl", 32'(mem_w && mem_r), 0);
            chk("ctn_range", 32'(count == 4 || count == 5), 1);
            if (i > 0) chk("ctn_alt", mem_w, !prev_w);
            prev_w = mem_w;
            tick();
            if (acc) nxt++;
        end

        // 40-word continuous stream wraps the pointers.
        pushed = 0;
        for (int n = 0; n < 300 && pushed < 40; n++) begin
            in_data = nxt;
            tick();
            if (acc) begin
                nxt++;
                pushed++;
            end
        end
        chk("stream_pushed", pushed, 40);
        drain();
        chk("stream_sb", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        push_until(7);
        chk("mid_out_valid", out_valid, 1);
        chk("mid_count", count, 7);
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_empty", empty, 1);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_mem_w", mem_w, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_data = 16'h00ab;
        #1;
        chk("post_w", mem_w, 1);
        chk("post_w_addr", mem_w_addr, 0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_r", mem_r, 1);
        chk("post_r_addr", mem_r_addr, 0);
        tick();
        chk("post_out_valid", out_valid, 1);
        chk("post_out_data", out_data, 16'h00ab);
        drain();
        chk("post_sb", 32'(exp_q.size()), 0);

`ifdef BUFFER_CTRL_ALMOST_FULL_EN
        out_ready = 1'b0;
        push_until(13);
        chk("af_13", almost_full, 0);
        push_until(14);
        chk("af_14", almost_full, 1);
        out_ready = 1'b1;
        tick();
        chk("af_fall_count", count, 13);
        chk("af_fall", almost_full, 0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
